onehot_decoder_skid: RTL

ONEHOT_DECODER_SKID -- requirements
Module: onehot_decoder_skid

---
 rtl/onehot_decoder_skid_pkg.sv | 14 +
 rtl/onehot_decoder_skid_if.sv | 28 ++
 rtl/onehot_decoder_skid_decoder.sv | 19 +
 rtl/onehot_decoder_skid.sv | 86 ++++++++
 4 files changed

// File: rtl/onehot_decoder_skid_pkg.sv
// Shared widths and occupancy encoding for the one-hot decoder skid buffer.
// Latency/backpressure are defined by the top module; this file holds types only.
package onehot_decoder_skid_pkg;

  localparam int IN_W_DEFAULT  = 3;
  localparam int OUT_W_DEFAULT = 2 ** IN_W_DEFAULT;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/onehot_decoder_skid_if.sv
// Valid/ready bus between a code producer and a one-hot word consumer.
// master drives codes and out_ready; slave (the buffer) returns in_ready and words.
interface onehot_decoder_skid_if
  import onehot_decoder_skid_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int OUT_W = 2 ** IN_W
);

  logic [IN_W-1:0]  in_code;
  logic             in_en;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_code, in_en, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_code, in_en, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/onehot_decoder_skid_decoder.sv
// Combinational binary-to-one-hot decoder with enable; zero word when disabled.
// Zero latency, no flow control.
module onehot_decoder #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  code,
  input  logic             en,
  output logic [OUT_W-1:0] word
);

  always_comb begin
    word = '0;
    if (en) begin
      word[code] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_decoder_skid.sv
// Decodes codes to one-hot words into a 2-entry skid buffer; 1-cycle latency.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
module onehot_decoder_skid
  import onehot_decoder_skid_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_decoder_skid_if.slave  bus
);

  occ_t             state, state_nxt;
  logic [OUT_W-1:0] head, head_nxt;
  logic [OUT_W-1:0] tail, tail_nxt;
  logic [OUT_W-1:0] dec_word;
  logic             push, pop;

  onehot_decoder #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .code (bus.in_code),
    .en   (bus.in_en),
    .word (dec_word)
  );

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  // head is kept zero whenever the buffer is empty, so no output gating is needed
  assign bus.out_data  = head;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_nxt  = dec_word;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = dec_word;
        end else if (push) begin
          state_nxt = FULL;
          tail_nxt  = dec_word;
        end else if (pop) begin
          state_nxt = EMPTY;
          head_nxt  = '0;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = ONE;
          head_nxt  = tail;
          tail_nxt  = '0;
        end
      end
      default: begin
        state_nxt = EMPTY;
        head_nxt  = '0;
        tail_nxt  = '0;
      end
    endcase
  end

endmodule
